// File: rtl/memif_pkg.sv
// Shared types and default sizes for the memory interface block.
package memif_pkg;

    localparam int DEF_ADDR_W      = 12;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_WAIT_CYCLES = 2;

    // Wait-state counter width; WAIT_CYCLES is limited to 0..15
    localparam int CNT_W = 4;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : memif_pkg

// File: rtl/mem_interface_if.sv
// Controller-to-memory bus: request/address/data from the controller,
// read data, read-valid pulse and active-low stall back to it.
interface mem_interface_if #(
    parameter int ADDR_W = memif_pkg::DEF_ADDR_W,
    parameter int DATA_W = memif_pkg::DEF_DATA_W
);
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              wait_;

    // Controller side
    modport master (
        output mem_rd, mem_wr, addr, wdata,
        input  rdata, rdata_valid, wait_
    );

    // Memory interface side
    modport slave (
        input  mem_rd, mem_wr, addr, wdata,
        output rdata, rdata_valid, wait_
    );
endinterface : mem_interface_if

// File: rtl/memory_array.sv
// Synchronous single-port RAM, 2^ADDR_W x DATA_W, with write enable and a
// registered read port. Only the read output register is cleared by reset;
// the storage array itself keeps its contents.
module memory_array #(
    parameter int ADDR_W = memif_pkg::DEF_ADDR_W,
    parameter int DATA_W = memif_pkg::DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    // Array write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Registered read; holds its value between reads
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : memory_array

// File: rtl/mem_interface.sv
// Memory interface between a microcoded controller and a single-port RAM.
// IDLE accepts a read or write (write wins if both), optional BUSY wait
// states count down, DONE presents the result for one cycle.
// Build option: MEMIF_WAITSTATE_EN enables the BUSY state and the
// WAIT_CYCLES wait-state counter; without it the access happens at the
// acceptance edge and wait_ is tied high.
module mem_interface
    import memif_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    mem_interface_if.slave   bus
);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("mem_interface: WAIT_CYCLES must be in 0..15");
    end

    state_t            r_state;
    state_t            w_state_next;
    logic              w_req;
    logic              w_access;
    logic              w_wait_n;
    logic              w_op_wr;
    logic              w_mem_we;
    logic              w_mem_re;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [DATA_W-1:0] w_mem_rdata;
    logic              r_rdata_valid;

    assign w_req = bus.mem_rd | bus.mem_wr;

`ifdef MEMIF_WAITSTATE_EN
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);

    logic [CNT_W-1:0]  r_cnt;
    logic              r_op_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    // Next state, access strobe and stall; reset overrides everything
    always_comb begin
        w_state_next = r_state;
        w_access     = 1'b0;
        w_wait_n     = 1'b1;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_state_next = BUSY;
                    w_wait_n     = 1'b0;
                end
            end
            BUSY: begin
                w_wait_n = 1'b0;
                if (r_cnt == '0) begin
                    w_access     = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                // Requests seen here are ignored; a held one restarts from IDLE
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (reset) begin
            w_access = 1'b0;
            w_wait_n = 1'b1;
        end
    end

    // Latch the request at acceptance and count down the wait states
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_op_wr <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (r_state == IDLE && w_req) begin
            r_cnt   <= CNT_INIT;
            r_op_wr <= bus.mem_wr;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
        end else if (r_state == BUSY && r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // The access uses only the latched request; the bus may change meanwhile
    assign w_op_wr     = r_op_wr;
    assign w_mem_addr  = r_addr;
    assign w_mem_wdata = r_wdata;
`else
    // Next state and access strobe; the access happens at acceptance
    always_comb begin
        w_state_next = r_state;
        w_access     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_access     = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (reset) begin
            w_access = 1'b0;
        end
    end

    // With no wait states the controller is never stalled
    assign w_wait_n    = 1'b1;
    assign w_op_wr     = bus.mem_wr;
    assign w_mem_addr  = bus.addr;
    assign w_mem_wdata = bus.wdata;
`endif

    // A simultaneous read+write request is treated as a write
    assign w_mem_we = w_access &  w_op_wr;
    assign w_mem_re = w_access & ~w_op_wr;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Read-valid pulse lands in DONE, the cycle after the read edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata_valid <= 1'b0;
        end else begin
            r_rdata_valid <= w_mem_re;
        end
    end

    // The RAM's read register doubles as the rdata holding register
    memory_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_memory_array (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (w_mem_addr),
        .i_wdata (w_mem_wdata),
        .o_rdata (w_mem_rdata)
    );

    assign bus.rdata       = w_mem_rdata;
    assign bus.rdata_valid = r_rdata_valid;
    assign bus.wait_       = w_wait_n;

endmodule : mem_interface
